// File: rtl/des_key_schedule.sv
// DES round-key generator: PC-1 on start, then one PC-2 round key per
// accepted handshake, K1..K16 for encryption or K16..K1 for decryption.
// Bit vectors use FIPS numbering (index 1 = MSB).
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:64] key_i,
  input  logic        decrypt_i,
  output logic [1:48] ki_o,
  output logic        ki_valid_o,
  input  logic        ki_ready_i,
  output logic [3:0]  round_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state_reg, state_next;
  logic [1:28] c_reg, c_next;
  logic [1:28] d_reg, d_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        dec_reg, dec_next;
  logic        done_reg, done_next;
  logic [1:48] ki_reg;
  logic        load;
  logic        one_step;
  logic [1:56] cd0;
  logic [1:56] cd_next;
  logic [1:48] ki_next;

  // Parity bits of the key are deliberately dropped by PC-1.
  logic unused_parity;
  assign unused_parity = ^{key_i[8], key_i[16], key_i[24], key_i[32],
                           key_i[40], key_i[48], key_i[56], key_i[64]};

  // PC-1 permutation of the incoming key into C0||D0.
  generate
    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
      assign cd0[gi+1] = key_i[PC1[gi]];
    end
  endgenerate

  // PC-2 applied to the C/D values about to be registered, so the key
  // register always tracks C/D with no extra cycle of latency.
  assign cd_next = {c_next, d_next};
  generate
    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
      assign ki_next[gi+1] = cd_next[PC2[gi]];
    end
  endgenerate

  // Rotate a 28-bit half by one or two places, left or right.
  function automatic logic [1:28] rot(input logic [1:28] v, input logic right, input logic one);
    if (!right) return one ? {v[2:28], v[1]} : {v[3:28], v[1:2]};
    else        return one ? {v[28], v[1:27]} : {v[27:28], v[1:26]};
  endfunction

  // The single-place steps fall after issue indices 0, 7 and 14 in both
  // directions, so one decode serves encryption and decryption.
  assign one_step = (cnt_reg == 4'd0) || (cnt_reg == 4'd7) || (cnt_reg == 4'd14);

  // Next-state and datapath control.
  always_comb begin
    state_next = state_reg;
    c_next     = c_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
    dec_next   = dec_reg;
    done_next  = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          c_next     = decrypt_i ? cd0[1:28]  : rot(cd0[1:28], 1'b0, 1'b1);
          d_next     = decrypt_i ? cd0[29:56] : rot(cd0[29:56], 1'b0, 1'b1);
          cnt_next   = 4'd0;
          dec_next   = decrypt_i;
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (ki_ready_i) begin
          if (cnt_reg != 4'd15) begin
            c_next   = rot(c_reg, dec_reg, one_step);
            d_next   = rot(d_reg, dec_reg, one_step);
            cnt_next = cnt_reg + 4'd1;
            load     = 1'b1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, C/D halves and the registered round key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      c_reg     <= '0;
      d_reg     <= '0;
      cnt_reg   <= '0;
      dec_reg   <= 1'b0;
      done_reg  <= 1'b0;
      ki_reg    <= '0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      d_reg     <= d_next;
      cnt_reg   <= cnt_next;
      dec_reg   <= dec_next;
      done_reg  <= done_next;
      if (load) ki_reg <= ki_next;
    end
  end

  assign ki_o       = ki_reg;
  assign ki_valid_o = (state_reg == RUN);
  assign busy_o     = (state_reg == RUN);
  assign round_o    = cnt_reg;
  assign done_o     = done_reg;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: expected round keys come from an independent
// bit-position model and are queued at start; a monitor pops one per handshake.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [63:0] key_i = '0;
  logic        decrypt_i = 1'b0;
  logic [47:0] ki_o;
  logic        ki_valid_o;
  logic        ki_ready_i = 1'b1;
  logic [3:0]  round_o;
  logic        busy_o;
  logic        done_o;

  des_key_schedule dut (
    .clk(clk), .rst(rst), .start_i(start_i), .key_i(key_i), .decrypt_i(decrypt_i),
    .ki_o(ki_o), .ki_valid_o(ki_valid_o), .ki_ready_i(ki_ready_i),
    .round_o(round_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [47:0] K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

  localparam int T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [51:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Round key r (1..16) computed from the cumulative rotation of C0/D0.
  function automatic logic [47:0] model_key(input logic [63:0] key, input int r);
    logic [55:0] cd0, cd;
    logic [27:0] c, d, cr, dr;
    logic [47:0] k;
    int tot = 0;
    for (int i = 0; i < 56; i++) cd0[55-i] = key[64-T_PC1[i]];
    for (int i = 0; i < r; i++) tot += T_SH[i];
    c = cd0[55:28];
    d = cd0[27:0];
    for (int j = 0; j < 28; j++) begin
      cr[27-j] = c[27-((j+tot)%28)];
      dr[27-j] = d[27-((j+tot)%28)];
    end
    cd = {cr, dr};
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-T_PC2[i]];
    return k;
  endfunction

  task automatic push_exp(input logic [63:0] key, input logic dec);
    for (int i = 0; i < 16; i++)
      exp_q.push_back({4'(i), model_key(key, dec ? 16 - i : i + 1)});
  endtask

  task automatic do_start(input logic [63:0] key, input logic dec);
    start_i   = 1'b1;
    key_i     = key;
    decrypt_i = dec;
    push_exp(key, dec);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ki", 64'(ki_o), 64'd0);
    chk("rst_valid", 64'(ki_valid_o), 64'd0);
    chk("rst_round", 64'(round_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
  endtask

  // Monitor: one scoreboard pop per handshake, plus stall stability checks.
  initial begin
    logic        prev_stall = 1'b0;
    logic [47:0] prev_ki = '0;
    logic [3:0]  prev_round = '0;
    logic [51:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(ki_valid_o), 64'd1);
          chk("stall_ki", 64'(ki_o), 64'(prev_ki));
          chk("stall_round", 64'(round_o), 64'(prev_round));
        end
        if (ki_valid_o && ki_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'(ki_o), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            $display("key round=%0d ki=%h expected=%h", round_o, ki_o, e[47:0]);
            chk("ki", 64'(ki_o), 64'(e[47:0]));
            chk("round", 64'(round_o), 64'(e[51:48]));
          end
        end
        if (done_o) done_cnt++;
        prev_stall = ki_valid_o && !ki_ready_i;
        prev_ki    = ki_o;
        prev_round = round_o;
      end
    end
  end

  // Drive one schedule to completion (or to an injected reset).
  task automatic run(input logic [47:0] first_exp, input bit rand_ready, input int stall15,
                     input int bad_start_at, input int rst_at_round, input bit chain,
                     output int nvalid, output int d15);
    int cyc = 0;
    int t15 = -1;
    int stall = stall15;
    bit fin = 0;
    nvalid = 0;
    d15 = -1;
    while (!fin) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      if (cyc == 0) begin
        chk("lat_valid", 64'(ki_valid_o), 64'd1);
        chk("lat_busy", 64'(busy_o), 64'd1);
        chk("first_ki", 64'(ki_o), 64'(first_exp));
      end
      if (cyc == bad_start_at) begin
        start_i   = 1'b1;
        key_i     = KEY2;
        decrypt_i = ~decrypt_i;
      end
      if (rst_at_round >= 0 && ki_valid_o && int'(round_o) == rst_at_round) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        exp_q.delete();
        fin = 1;
      end else begin
        if (ki_valid_o) nvalid++;
        if (ki_valid_o && round_o == 4'd15 && t15 < 0) t15 = cyc;
        if (done_o) begin
          d15 = cyc - t15;
          fin = 1;
          if (chain) do_start(KEY, 1'b1);
        end else if (ki_valid_o && round_o == 4'd15) begin
          ki_ready_i = (stall > 0) ? 1'b0 : 1'b1;
          if (stall > 0) stall--;
        end else begin
          ki_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
      cyc++;
      if (!fin && cyc > 300) begin
        chk("timeout", 64'(cyc), 64'd0);
        fin = 1;
      end
    end
  endtask

  initial begin
    int nv, d, dbase;
    logic [63:0] rk;
    logic rdec;

    idle(3);
    chk_reset_outputs();
    rst = 1'b0;
    idle(2);
    chk("idle_busy", 64'(busy_o), 64'd0);

    // Encrypt at full rate.
    dbase = done_cnt;
    do_start(KEY, 1'b0);
    run(K1, 0, 0, -1, -1, 0, nv, d);
    chk("t1_nvalid", 64'(nv), 64'd16);
    chk("t1_done_delay", 64'(d), 64'd1);
    chk("t1_busy_at_done", 64'(busy_o), 64'd0);
    idle(3);
    chk("t1_done_pulses", 64'(done_cnt - dbase), 64'd1);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // Decrypt: reversed order.
    dbase = done_cnt;
    do_start(KEY, 1'b1);
    run(K16, 0, 0, -1, -1, 0, nv, d);
    chk("t2_nvalid", 64'(nv), 64'd16);
    idle(3);
    chk("t2_done_pulses", 64'(done_cnt - dbase), 64'd1);
    chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Random back-pressure with a 5-cycle stall on the last key.
    do_start(KEY, 1'b0);
    run(K1, 1, 5, -1, -1, 0, nv, d);
    chk("t3_done_delay", 64'(d), 64'd6);
    idle(2);
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Start pulse with a different key during RUN is ignored.
    do_start(KEY, 1'b0);
    run(K1, 0, 0, 5, -1, 0, nv, d);
    chk("t4_nvalid", 64'(nv), 64'd16);
    decrypt_i = 1'b0;
    idle(3);
    chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t4_idle_busy", 64'(busy_o), 64'd0);

    // Reset at issue index 7 aborts without done, then a clean restart.
    dbase = done_cnt;
    do_start(KEY, 1'b0);
    run(K1, 0, 0, -1, 7, 0, nv, d);
    idle(3);
    chk("t5_no_done", 64'(done_cnt - dbase), 64'd0);
    do_start(KEY, 1'b0);
    run(K1, 0, 0, -1, -1, 0, nv, d);
    chk("t5_nvalid", 64'(nv), 64'd16);
    idle(2);
    chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    // Back-to-back: decrypt started in the done cycle.
    dbase = done_cnt;
    do_start(KEY, 1'b0);
    run(K1, 0, 0, -1, -1, 1, nv, d);
    run(K16, 0, 0, -1, -1, 0, nv, d);
    chk("t6_nvalid", 64'(nv), 64'd16);
    idle(3);
    chk("t6_done_pulses", 64'(done_cnt - dbase), 64'd2);
    chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);

    // A few random keys and directions under random back-pressure.
    for (int n = 0; n < 3; n++) begin
      rk   = {$urandom, $urandom};
      rdec = 1'($urandom_range(0, 1));
      do_start(rk, rdec);
      run(model_key(rk, rdec ? 16 : 1), 1, 0, -1, -1, 0, nv, d);
      idle(2);
      chk("rnd_sb_empty", 64'(exp_q.size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
